reg_write_sequencer: RTL
========================

Name: reg_write_sequencer

Overview:
- Initiator side of the register-file write interface. Buffers destination-register write requests from the datapath in an in-order queue.
- Issues at most one write per cycle onto the register file's regWrite/writeReg/writeData port.
- Keeps a scoreboard of pending destinations and provides forwarding of the youngest queued value.
- Sits between the writeback mux and the register file; the hazard unit reads busy.

Parameters:
- DATA_W, 16, write data width (matches register file word).
- ADDR_W, 3, register index width (8 registers).
- DEPTH, 4, queue entries; power of two, >= 2.
- DROP_R0, 1, when 1, requests to register 0 are accepted and discarded.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept the request this cycle.
- in_reg  in  ADDR_W  destination register.
- in_data  in  DATA_W  value to write.
- wb_hold  in  1  register-file write slot unavailable this cycle.
- flush  in  1  discard all queued entries.
- regWrite  out  1  register-file write enable.
- writeReg  out  ADDR_W  register-file write index.
- writeData  out  DATA_W  register-file write data.
- busy  out  2**ADDR_W  bit i set when any queued entry targets register i.
- fwd_reg  in  ADDR_W  forwarding lookup index.
- fwd_hit  out  1  a queued entry targets fwd_reg.
- fwd_data  out  DATA_W  data of the youngest matching entry; 0 when no hit.
- empty  out  1  queue holds no entries.

Behaviour:
- Reset (rst=1 at an edge): count=0, read/write pointers=0. Entry contents are don't-care.
  - Resulting outputs: regWrite=0, writeReg=0, writeData=0, busy=0, fwd_hit=0, fwd_data=0, empty=1, in_ready=1.
  - rst overrides flush, enqueue and dequeue in the same cycle.
- Storage: circular buffer of DEPTH {reg, data} entries, plus a count of 0..DEPTH.
  - Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH).
  - No pass-through: a dequeue in the same cycle does not raise in_ready when full.
- Enqueue occurs when in_valid & in_ready & ~flush.
  - If DROP_R0=1 and in_reg==0, the request is handshaken but not stored; count is unchanged.
- Dequeue:
  - regWrite = (count != 0) & ~wb_hold & ~flush, combinational from registered state.
  - The head entry is popped at the edge where regWrite=1.
- writeReg/writeData:
  - equal the head entry when count != 0;
  - forced to 0 when empty.
- Latency: a request accepted at edge N appears on the write port no earlier than the cycle after edge N. Zero-cycle bypass to the write port is not allowed.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Ordering: strictly FIFO. Two entries to the same register are both written, oldest first.
- busy:
  - OR over valid entries of one-hot(entry.reg), from registered state only;
  - an entry popped this cycle still shows busy this cycle.
- Forwarding, combinational from registered state:
  - fwd_hit = any valid entry with reg == fwd_reg;
  - fwd_data = data of the youngest such entry (closest to the write pointer);
  - an entry being enqueued this cycle is not visible until the next cycle.
- flush=1 at an edge:
  - count is set to 0 and the pointers are set equal;
  - no write is issued that cycle;
  - an in_valid in that cycle is dropped;
  - in_ready still reflects the pre-flush count.
- wb_hold=1 freezes the head entry. Enqueue continues until the queue is full.
- Mid-operation reset discards queued entries with no write issued. The regFile itself is reset by the same rst.

Decomposition:
- Shared package:
  - DATA_W and ADDR_W constants, shared with regFile;
  - wb_entry typedef {reg[ADDR_W], data[DATA_W]};
  - NUM_REGS = 2**ADDR_W.
- One natural sub-module: wb_fifo, the circular buffer with count, pointers, push/pop and full/empty flags.
- The scoreboard and the youngest-match forwarding priority logic stay in the top level, iterating entries from the head by age.

Test Plan:
- Reset, then enqueue {reg 3, 0x1234} -> next cycle regWrite=1, writeReg=3, writeData=0x1234, busy=0x08; the cycle after: empty=1, busy=0.
- wb_hold=1, enqueue 4 entries to regs 1, 2, 3, 4 -> in_ready=0 after the 4th; a 5th request is not accepted.
  - Release hold -> writes issued in order 1, 2, 3, 4 on consecutive cycles.
- Enqueue {5, 0x00AA} then {5, 0x00BB} with hold; fwd_reg=5 -> fwd_hit=1, fwd_data=0x00BB.
  - Release hold -> both writes issued, 0x00AA first.
- DROP_R0=1: enqueue {0, 0xFFFF} -> in_ready=1, no write issued, count stays 0, busy[0]=0.
- Hold with 3 entries queued, then assert flush together with in_valid {6, 0x0042} -> after the edge empty=1, busy=0, and reg 6 is never written.
- Enqueue and dequeue in the same cycle at count=DEPTH-1 across pointer wrap -> count stays DEPTH-1, data is intact.
  - Assert rst mid-stream -> all outputs 0 and empty=1 next cycle.

Source files
------------

// File: rtl/reg_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_sequencer_pkg
// Description : Shared constants and types for the register-file write path.
//               RF_DATA_W / RF_ADDR_W are the register file's word and index
//               widths. wb_entry_t is one queued {destination, value} write.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_write_sequencer_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

  // One pending register-file write. "dst" is the destination register index.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] dst;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage : reg_write_sequencer_pkg
`default_nettype wire

// File: rtl/reg_write_sequencer_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer of {reg, data} write entries with occupancy
//               count. Every slot is exposed so the parent can scan the
//               queue by age starting from rd_ptr_o.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               push_i/pop_i       - store one entry / retire the head entry
//               flush_i            - drop all entries (wins over push/pop)
//               push_reg_i/_data_i - entry being stored
//               head_reg_o/_data_o - oldest entry (don't-care when empty)
//               ent_reg_o/_data_o  - raw slot contents, indexed by slot
//               rd_ptr_o, count_o  - head slot and number of valid entries
//               full_o, empty_o    - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import reg_write_sequencer_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [ADDR_W-1:0]             push_reg_i,
  input  logic [DATA_W-1:0]             push_data_i,
  output logic [ADDR_W-1:0]             head_reg_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg_o,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data_o,
  output logic [PTR_W-1:0]              rd_ptr_o,
  output logic [CNT_W-1:0]              count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("wb_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [DEPTH-1:0][ADDR_W-1:0] mem_reg_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data_q;
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic                         w_push;
  logic                         w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Self-protecting: never overfill, never underflow, nothing moves on flush.
  assign w_push = push_i & ~full_o  & ~flush_i;
  assign w_pop  = pop_i  & ~empty_o & ~flush_i;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
  // natural binary wrap is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot contents carry no reset: validity is defined solely by count_q.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_reg_q[wr_ptr_q]  <= push_reg_i;
      mem_data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_reg_o  = mem_reg_q[rd_ptr_q];
  assign head_data_o = mem_data_q[rd_ptr_q];
  assign ent_reg_o   = mem_reg_q;
  assign ent_data_o  = mem_data_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/reg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_sequencer
// Description : Initiator side of the register-file write port. Queues
//               writeback requests in order, issues at most one write per
//               cycle, publishes a busy scoreboard of pending destinations
//               and forwards the youngest queued value for a lookup index.
// Ports       : clk, rst                     - clock, sync active-high reset
//               in_valid/in_ready/in_reg/in_data - request handshake
//               wb_hold                      - write slot unavailable
//               flush                        - discard all queued entries
//               regWrite/writeReg/writeData  - register-file write port
//               busy                         - per-register pending mask
//               fwd_reg/fwd_hit/fwd_data     - forwarding lookup
//               empty                        - queue holds no entries
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_sequencer
  import reg_write_sequencer_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_reg,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   wb_hold,
  input  logic                   flush,
  output logic                   regWrite,
  output logic [ADDR_W-1:0]      writeReg,
  output logic [DATA_W-1:0]      writeData,
  output logic [2**ADDR_W-1:0]   busy,
  input  logic [ADDR_W-1:0]      fwd_reg,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                         w_full;
  logic                         w_empty;
  logic                         w_accept;
  logic                         w_drop;
  logic                         w_push;
  logic [ADDR_W-1:0]            w_head_reg;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_reg;
  logic [DEPTH-1:0][DATA_W-1:0] w_ent_data;
  logic [PTR_W-1:0]             w_rd_ptr;
  logic [CNT_W-1:0]             w_count;

  // No pass-through: a pop in the same cycle never frees a full queue.
  assign in_ready = ~w_full;
  assign w_accept = in_valid & in_ready & ~flush;
  // Writes to register 0 are handshaken but never stored.
  assign w_drop   = DROP_R0 && (in_reg == '0);
  assign w_push   = w_accept & ~w_drop;

  // Driven purely by registered occupancy, so a request accepted this cycle
  // cannot reach the write port before the next cycle.
  assign regWrite  = ~w_empty & ~wb_hold & ~flush;
  assign writeReg  = w_empty ? '0 : w_head_reg;
  assign writeData = w_empty ? '0 : w_head_data;
  assign empty     = w_empty;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .pop_i       (regWrite),
    .flush_i     (flush),
    .push_reg_i  (in_reg),
    .push_data_i (in_data),
    .head_reg_o  (w_head_reg),
    .head_data_o (w_head_data),
    .ent_reg_o   (w_ent_reg),
    .ent_data_o  (w_ent_data),
    .rd_ptr_o    (w_rd_ptr),
    .count_o     (w_count),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  // Scan valid entries oldest to youngest starting at the head. A later
  // match overwrites an earlier one, so the youngest matching entry wins.
  always_comb begin
    busy     = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < w_count) begin
        busy[w_ent_reg[w_rd_ptr + PTR_W'(i)]] = 1'b1;
        if (w_ent_reg[w_rd_ptr + PTR_W'(i)] == fwd_reg) begin
          fwd_hit  = 1'b1;
          fwd_data = w_ent_data[w_rd_ptr + PTR_W'(i)];
        end
      end
    end
  end

endmodule : reg_write_sequencer
`default_nettype wire
